// File: rtl/tomasulo_pkg.sv
// Shared widths, func codes and reservation-station entry layout for the
// Tomasulo issue/execute back end.
package tomasulo_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int FUNC_W = 4;
  localparam int REG_W  = 4;

  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'b0000;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'b0001;
  localparam logic [FUNC_W-1:0] FUNC_MUL = 4'b0010;
  localparam logic [FUNC_W-1:0] FUNC_DIV = 4'b0011;
  localparam logic [FUNC_W-1:0] FUNC_BEQ = 4'b0100;
  localparam logic [FUNC_W-1:0] FUNC_BNE = 4'b0101;

  // When an sN_rdy bit is clear, sN[TAG_W-1:0] holds the producing ROB tag.
  typedef struct packed {
    logic              valid;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [TAG_W-1:0]  rob;
    logic              s1_rdy;
    logic [DATA_W-1:0] s1;
    logic              s2_rdy;
    logic [DATA_W-1:0] s2;
  } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Oldest-ready picker: grants the lowest-index set ready bit.
module rs_select #(
  parameter int N = 3
) (
  input  logic [N-1:0] ready,
  output logic [N-1:0] grant,
  output logic         found
);

  // Priority scan from index 0 (oldest) upward
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      grant[i] = ready[i] & ~found;
      found    = found | ready[i];
    end
  end

endmodule

// File: rtl/rs_alu_station.sv
// Collapsing-queue reservation station with CDB wakeup/bypass and a
// valid/ready dispatch register towards one functional-unit class.
module rs_alu_station #(
  parameter int         NUM_ENTRIES = 3,
  parameter int         DATA_W      = 16,
  parameter int         TAG_W       = 3,
  parameter logic [3:0] FUNC_LO     = 4'b0000,
  parameter logic [3:0] FUNC_HI     = 4'b0001
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        in_func,
  input  logic [3:0]        in_rd,
  input  logic [TAG_W-1:0]  in_rob,
  input  logic              in_s1_rdy,
  input  logic [DATA_W-1:0] in_s1,
  input  logic              in_s2_rdy,
  input  logic [DATA_W-1:0] in_s2,
  output logic              in_ready,
  output logic [1:0]        occupancy,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              flush,
  output logic              fu_valid,
  input  logic              fu_ready,
  output logic [3:0]        fu_func,
  output logic [3:0]        fu_rd,
  output logic [TAG_W-1:0]  fu_rob,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b
);
  import tomasulo_pkg::*;

  localparam int         IDX_W     = $clog2(NUM_ENTRIES);
  localparam logic [3:0] FUNC_SPAN = FUNC_HI - FUNC_LO;

  rs_entry_t              entries_q [NUM_ENTRIES];
  rs_entry_t              entries_d [NUM_ENTRIES];
  rs_entry_t              woken [NUM_ENTRIES+1];
  rs_entry_t              new_entry;
  logic [1:0]             occ_q, occ_d;
  logic                   fu_valid_q, fu_valid_d;
  logic [3:0]             fu_func_q, fu_func_d;
  logic [3:0]             fu_rd_q, fu_rd_d;
  logic [TAG_W-1:0]       fu_rob_q, fu_rob_d;
  logic [DATA_W-1:0]      fu_a_q, fu_a_d;
  logic [DATA_W-1:0]      fu_b_q, fu_b_d;
  logic [NUM_ENTRIES-1:0] ready_vec, grant;
  logic                   found, dispatch, alloc;
  logic                   s1_byp, s2_byp, w1, w2;
  logic [IDX_W-1:0]       sel_idx, wr_idx;
  logic [3:0]             func_off;

  // Select works on registered state, so a wakeup dispatches one cycle later
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ready_vec[i] = entries_q[i].valid & entries_q[i].s1_rdy & entries_q[i].s2_rdy;
    end
  end

  rs_select #(.N(NUM_ENTRIES)) u_select (
    .ready (ready_vec),
    .grant (grant),
    .found (found)
  );

  // Next-state for queue, occupancy and dispatch register
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      sel_idx = sel_idx | (grant[i] ? IDX_W'(i) : '0);
    end

    in_ready = (occ_q < 2'(NUM_ENTRIES));
    func_off = in_func - FUNC_LO;
    alloc    = in_valid & in_ready & (func_off <= FUNC_SPAN);
    dispatch = found & (~fu_valid_q | fu_ready);
    wr_idx   = IDX_W'(occ_q - {1'b0, dispatch});

    s1_byp           = cdb_valid & ~in_s1_rdy & (in_s1[TAG_W-1:0] == cdb_tag);
    s2_byp           = cdb_valid & ~in_s2_rdy & (in_s2[TAG_W-1:0] == cdb_tag);
    new_entry.valid  = 1'b1;
    new_entry.func   = in_func;
    new_entry.rd     = in_rd;
    new_entry.rob    = in_rob;
    new_entry.s1_rdy = in_s1_rdy | s1_byp;
    new_entry.s1     = s1_byp ? cdb_value : in_s1;
    new_entry.s2_rdy = in_s2_rdy | s2_byp;
    new_entry.s2     = s2_byp ? cdb_value : in_s2;

    w1 = 1'b0;
    w2 = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w1 = cdb_valid & entries_q[i].valid & ~entries_q[i].s1_rdy &
           (entries_q[i].s1[TAG_W-1:0] == cdb_tag);
      w2 = cdb_valid & entries_q[i].valid & ~entries_q[i].s2_rdy &
           (entries_q[i].s2[TAG_W-1:0] == cdb_tag);
      woken[i]        = entries_q[i];
      woken[i].s1_rdy = entries_q[i].s1_rdy | w1;
      woken[i].s1     = w1 ? cdb_value : entries_q[i].s1;
      woken[i].s2_rdy = entries_q[i].s2_rdy | w2;
      woken[i].s2     = w2 ? cdb_value : entries_q[i].s2;
    end
    woken[NUM_ENTRIES] = '0;

    // New entry lands above the survivors; dispatch collapses the hole
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (flush) begin
        entries_d[i] = '0;
      end else if (alloc && (IDX_W'(i) == wr_idx)) begin
        entries_d[i] = new_entry;
      end else if (dispatch && (IDX_W'(i) >= sel_idx)) begin
        entries_d[i] = woken[i+1];
      end else begin
        entries_d[i] = woken[i];
      end
    end

    occ_d      = flush ? 2'd0 : (occ_q + {1'b0, alloc} - {1'b0, dispatch});
    fu_valid_d = fu_valid_q;
    fu_func_d  = fu_func_q;
    fu_rd_d    = fu_rd_q;
    fu_rob_d   = fu_rob_q;
    fu_a_d     = fu_a_q;
    fu_b_d     = fu_b_q;
    if (flush) begin
      fu_valid_d = 1'b0;
    end else if (dispatch) begin
      fu_valid_d = 1'b1;
      fu_func_d  = entries_q[sel_idx].func;
      fu_rd_d    = entries_q[sel_idx].rd;
      fu_rob_d   = entries_q[sel_idx].rob;
      fu_a_d     = entries_q[sel_idx].s1;
      fu_b_d     = entries_q[sel_idx].s2;
    end else if (fu_ready) begin
      fu_valid_d = 1'b0;
    end else begin
      fu_valid_d = fu_valid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk1) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
      occ_q      <= 2'd0;
      fu_valid_q <= 1'b0;
      fu_func_q  <= 4'd0;
      fu_rd_q    <= 4'd0;
      fu_rob_q   <= '0;
      fu_a_q     <= '0;
      fu_b_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries_q[i] <= entries_d[i];
      end
      occ_q      <= occ_d;
      fu_valid_q <= fu_valid_d;
      fu_func_q  <= fu_func_d;
      fu_rd_q    <= fu_rd_d;
      fu_rob_q   <= fu_rob_d;
      fu_a_q     <= fu_a_d;
      fu_b_q     <= fu_b_d;
    end
  end

  assign occupancy = occ_q;
  assign fu_valid  = fu_valid_q;
  assign fu_func   = fu_func_q;
  assign fu_rd     = fu_rd_q;
  assign fu_rob    = fu_rob_q;
  assign fu_a      = fu_a_q;
  assign fu_b      = fu_b_q;

endmodule

// File: tb/tb_rs_alu_station.sv
// Directed, table-driven bench for the add/sub reservation station.
module tb_rs_alu_station;
  import tomasulo_pkg::*;

  logic        clk1 = 1'b0;
  logic        reset, in_valid, in_s1_rdy, in_s2_rdy, cdb_valid, flush, fu_ready;
  logic [3:0]  in_func, in_rd, fu_func, fu_rd;
  logic [2:0]  in_rob, cdb_tag, fu_rob;
  logic [15:0] in_s1, in_s2, cdb_value, fu_a, fu_b;
  logic        in_ready, fu_valid;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk1 = ~clk1;

  rs_alu_station #(
    .NUM_ENTRIES(3), .DATA_W(16), .TAG_W(3), .FUNC_LO(4'b0000), .FUNC_HI(4'b0001)
  ) dut (
    .clk1(clk1), .reset(reset), .in_valid(in_valid), .in_func(in_func), .in_rd(in_rd),
    .in_rob(in_rob), .in_s1_rdy(in_s1_rdy), .in_s1(in_s1), .in_s2_rdy(in_s2_rdy),
    .in_s2(in_s2), .in_ready(in_ready), .occupancy(occupancy), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value), .flush(flush), .fu_valid(fu_valid),
    .fu_ready(fu_ready), .fu_func(fu_func), .fu_rd(fu_rd), .fu_rob(fu_rob),
    .fu_a(fu_a), .fu_b(fu_b)
  );

  typedef struct {
    logic iv; logic [3:0] func; logic [3:0] rd; logic [2:0] rob;
    logic r1; logic [15:0] s1; logic r2; logic [15:0] s2;
    logic cv; logic [2:0] ct; logic [15:0] cval;
    logic fl; logic fr;
    logic e_fv; logic [2:0] e_rob; logic [3:0] e_rd;
    logic [15:0] e_a; logic [15:0] e_b; logic [1:0] e_occ;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(
    input logic iv, input logic [3:0] func, input logic [3:0] rd, input logic [2:0] rob,
    input logic r1, input logic [15:0] s1, input logic r2, input logic [15:0] s2,
    input logic cv, input logic [2:0] ct, input logic [15:0] cval,
    input logic fl, input logic fr,
    input logic e_fv, input logic [2:0] e_rob, input logic [3:0] e_rd,
    input logic [15:0] e_a, input logic [15:0] e_b, input logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.func = func; v.rd = rd; v.rob = rob;
    v.r1 = r1; v.s1 = s1; v.r2 = r2; v.s2 = s2;
    v.cv = cv; v.ct = ct; v.cval = cval; v.fl = fl; v.fr = fr;
    v.e_fv = e_fv; v.e_rob = e_rob; v.e_rd = e_rd; v.e_a = e_a; v.e_b = e_b; v.e_occ = e_occ;
    return v;
  endfunction

  function automatic vec_t idl(input logic fr, input logic e_fv, input logic [2:0] e_rob,
                               input logic [3:0] e_rd, input logic [15:0] e_a,
                               input logic [15:0] e_b, input logic [1:0] e_occ);
    return mk(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0, 16'd0,
              1'b0, fr, e_fv, e_rob, e_rd, e_a, e_b, e_occ);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic apply(input vec_t v);
    in_valid = v.iv; in_func = v.func; in_rd = v.rd; in_rob = v.rob;
    in_s1_rdy = v.r1; in_s1 = v.s1; in_s2_rdy = v.r2; in_s2 = v.s2;
    cdb_valid = v.cv; cdb_tag = v.ct; cdb_value = v.cval;
    flush = v.fl; fu_ready = v.fr;
  endtask

  task automatic issue(input logic [3:0] func, input logic [3:0] rd, input logic [2:0] rob,
                       input logic r1, input logic [15:0] s1,
                       input logic r2, input logic [15:0] s2);
    in_valid = 1'b1; in_func = func; in_rd = rd; in_rob = rob;
    in_s1_rdy = r1; in_s1 = s1; in_s2_rdy = r2; in_s2 = s2;
    cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_fu(input string tag, input logic fv, input logic [2:0] rob,
                        input logic [15:0] a, input logic [15:0] b, input logic [1:0] occ);
    chk({tag, " fu_valid"}, 32'(fu_valid), 32'(fv));
    chk({tag, " occupancy"}, 32'(occupancy), 32'(occ));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(occ != 2'd3));
    if (fv) begin
      chk({tag, " fu_rob"}, 32'(fu_rob), 32'(rob));
      chk({tag, " fu_a"}, 32'(fu_a), 32'(a));
      chk({tag, " fu_b"}, 32'(fu_b), 32'(b));
    end
  endtask

  initial begin
    // Basic ready-ready issue and dispatch
    vecs.push_back(mk(1'b1, FUNC_ADD, 4'd1, 3'd2, 1'b1, 16'd5, 1'b1, 16'd7, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd1));
    vecs.push_back(idl(1'b1, 1'b1, 3'd2, 4'd1, 16'd5, 16'd7, 2'd0));
    vecs.push_back(idl(1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd0));
    // Operand waiting on tag 3, woken by CDB
    vecs.push_back(mk(1'b1, FUNC_ADD, 4'd2, 3'd4, 1'b0, 16'd3, 1'b1, 16'd4, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd1));
    vecs.push_back(idl(1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd1));
    vecs.push_back(mk(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 3'd3, 16'h0010, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd1));
    vecs.push_back(idl(1'b1, 1'b1, 3'd4, 4'd2, 16'h0010, 16'd4, 2'd0));
    vecs.push_back(idl(1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd0));
    // Fill to capacity on tag 1, fourth issue refused, drain in order
    vecs.push_back(mk(1'b1, FUNC_ADD, 4'd3, 3'd5, 1'b0, 16'd1, 1'b1, 16'd1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd1));
    vecs.push_back(mk(1'b1, FUNC_SUB, 4'd4, 3'd6, 1'b0, 16'd1, 1'b1, 16'd2, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd2));
    vecs.push_back(mk(1'b1, FUNC_ADD, 4'd5, 3'd7, 1'b0, 16'd1, 1'b1, 16'd3, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd3));
    vecs.push_back(mk(1'b1, FUNC_ADD, 4'd6, 3'd0, 1'b1, 16'd9, 1'b1, 16'd9, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd3));
    vecs.push_back(mk(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 3'd1, 16'h0100, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd3));
    vecs.push_back(idl(1'b1, 1'b1, 3'd5, 4'd3, 16'h0100, 16'd1, 2'd2));
    vecs.push_back(idl(1'b1, 1'b1, 3'd6, 4'd4, 16'h0100, 16'd2, 2'd1));
    vecs.push_back(idl(1'b1, 1'b1, 3'd7, 4'd5, 16'h0100, 16'd3, 2'd0));
    vecs.push_back(idl(1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd0));
    // Alloc during dispatch, then flush with a pending issue, then out-of-range func
    vecs.push_back(mk(1'b1, FUNC_ADD, 4'd7, 3'd1, 1'b1, 16'h0011, 1'b1, 16'h0022, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd1));
    vecs.push_back(mk(1'b1, FUNC_ADD, 4'd8, 3'd2, 1'b0, 16'd5, 1'b1, 16'h0044, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b1, 3'd1, 4'd7, 16'h0011, 16'h0022, 2'd1));
    vecs.push_back(mk(1'b1, FUNC_SUB, 4'd9, 3'd3, 1'b0, 16'd5, 1'b1, 16'h0055, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 3'd1, 4'd7, 16'h0011, 16'h0022, 2'd2));
    vecs.push_back(mk(1'b1, FUNC_ADD, 4'd10, 3'd4, 1'b1, 16'd1, 1'b1, 16'd1, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd0));
    vecs.push_back(mk(1'b1, FUNC_MUL, 4'd11, 3'd5, 1'b1, 16'd1, 1'b1, 16'd1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd0));
    vecs.push_back(idl(1'b1, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 2'd0));

    // Reset overrides a simultaneous issue and broadcast
    reset = 1'b1; fu_ready = 1'b0;
    issue(FUNC_ADD, 4'd1, 3'd1, 1'b1, 16'd3, 1'b1, 16'd3);
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 16'd8;
    repeat (3) step();
    chk("reset fu_valid", 32'(fu_valid), 32'd0);
    chk("reset occupancy", 32'(occupancy), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset fu_func", 32'(fu_func), 32'd0);
    chk("reset fu_rd", 32'(fu_rd), 32'd0);
    chk("reset fu_rob", 32'(fu_rob), 32'd0);
    chk("reset fu_a", 32'(fu_a), 32'd0);
    chk("reset fu_b", 32'(fu_b), 32'd0);
    reset = 1'b0;
    idle();

    foreach (vecs[k]) begin
      apply(vecs[k]);
      step();
      chk_fu($sformatf("row%0d", k), vecs[k].e_fv, vecs[k].e_rob, vecs[k].e_a,
             vecs[k].e_b, vecs[k].e_occ);
      if (vecs[k].e_fv) begin
        chk($sformatf("row%0d fu_rd", k), 32'(fu_rd), 32'(vecs[k].e_rd));
      end
    end

    // Back-pressure: output held stable until fu_ready, then next entry follows
    issue(FUNC_ADD, 4'd1, 3'd1, 1'b1, 16'h00A1, 1'b1, 16'h00B1); fu_ready = 1'b0;
    step(); chk_fu("hold0", 1'b0, 3'd0, 16'd0, 16'd0, 2'd1);
    issue(FUNC_SUB, 4'd2, 3'd2, 1'b1, 16'h00A2, 1'b1, 16'h00B2);
    step(); chk_fu("hold1", 1'b1, 3'd1, 16'h00A1, 16'h00B1, 2'd1);
    idle();
    for (int c = 0; c < 3; c++) begin
      step();
      chk_fu($sformatf("hold_stall%0d", c), 1'b1, 3'd1, 16'h00A1, 16'h00B1, 2'd1);
      chk($sformatf("hold_stall%0d fu_func", c), 32'(fu_func), 32'(FUNC_ADD));
    end
    fu_ready = 1'b1;
    step(); chk_fu("hold_release", 1'b1, 3'd2, 16'h00A2, 16'h00B2, 2'd0);
    chk("hold_release fu_func", 32'(fu_func), 32'(FUNC_SUB));
    step(); chk_fu("hold_drain", 1'b0, 3'd0, 16'd0, 16'd0, 2'd0);

    // CDB bypass on the allocation cycle
    issue(FUNC_ADD, 4'd3, 3'd3, 1'b1, 16'h0033, 1'b0, 16'd6);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_value = 16'd9;
    step(); chk_fu("bypass_alloc", 1'b0, 3'd0, 16'd0, 16'd0, 2'd1);
    idle();
    step(); chk_fu("bypass_disp", 1'b1, 3'd3, 16'h0033, 16'd9, 2'd0);
    step(); chk_fu("bypass_drain", 1'b0, 3'd0, 16'd0, 16'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
